// File: rtl/scan_pkg.sv
// Shared definitions for the 8-digit display scan controller.
// Slot geometry (digit count, select width, nibble width) and the scan FSM states.
package scan_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int SEL_W      = 3;
    localparam int NIB_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_dwell_timer.sv
// Dwell timer for the scan controller.
// It counts up from 0 while run is high. done is high while the count equals the
// terminal value tc. On the cycle after done, the count wraps back to 0.
// clr forces the count to 0 and takes priority over run.
module scan_dwell_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic [CNT_W-1:0] tc,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Count register: clear wins, then wrap at terminal, else increment while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            if (done) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign done = (cnt == tc);

endmodule

// File: rtl/scan_ctrl8.sv
// Time-multiplexed 8-digit display scan controller.
// It feeds a 3-to-8 active-low digit decoder: sel -> C,B,A and sel_en -> EN.
// hex carries the nibble of the current slot to the segment encoder.
// Build option: define SCAN_BLANK_EN to insert a BLANK_CYC-cycle blanking gap
// after every dwell. This suppresses ghosting.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | scan stopped, sel parked at 0, decoder disabled
//   SHOW  | current slot driven for DIV cycles (lit if its mask bit is 1)
//   BLANK | decoder disabled for BLANK_CYC cycles before next slot
//         | (present only when SCAN_BLANK_EN is defined)
module scan_ctrl8
    import scan_pkg::*;
#(
    parameter int DIV       = 4,
    parameter int BLANK_CYC = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NUM_DIGITS*NIB_W-1:0] digits,
    input  logic [NUM_DIGITS-1:0]       mask,
    output logic [SEL_W-1:0]            sel,
    output logic                        sel_en,
    output logic [NIB_W-1:0]            hex,
    output logic                        frame
);

    localparam int MAX_CYC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] TC_SHOW  = CNT_W'(DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

    scan_state_t      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             frame_q, frame_d;
    logic             tmr_clr, tmr_run, tmr_done;
    logic [CNT_W-1:0] tmr_tc;

`ifdef SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] TC_BLANK = CNT_W'(BLANK_CYC - 1);
    assign tmr_tc = (state_q == BLANK) ? TC_BLANK : TC_SHOW;
`else
    assign tmr_tc = TC_SHOW;
`endif

    scan_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .run  (tmr_run),
        .tc   (tmr_tc),
        .done (tmr_done)
    );

    // State, slot index and frame pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            frame_q <= frame_d;
        end
    end

    // Next-state logic. Dropping en stops the scan at once, with no wait for the dwell to end.
    // frame is flagged only when slot 7 hands over to slot 0.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        frame_d = 1'b0;
        tmr_clr = 1'b0;
        tmr_run = 1'b0;
        if (!en) begin
            state_d = IDLE;
            sel_d   = '0;
            tmr_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    sel_d   = '0;
                    tmr_clr = 1'b1;
                end
                SHOW: begin
                    tmr_run = 1'b1;
                    if (tmr_done) begin
`ifdef SCAN_BLANK_EN
                        state_d = BLANK;
`else
                        sel_d   = sel_q + SEL_W'(1);
                        frame_d = (sel_q == SEL_LAST);
`endif
                    end
                end
`ifdef SCAN_BLANK_EN
                BLANK: begin
                    tmr_run = 1'b1;
                    if (tmr_done) begin
                        state_d = SHOW;
                        sel_d   = sel_q + SEL_W'(1);
                        frame_d = (sel_q == SEL_LAST);
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    sel_d   = '0;
                    tmr_clr = 1'b1;
                end
            endcase
        end
    end

    assign sel    = sel_q;
    assign frame  = frame_q;
    assign hex    = digits[{sel_q, 2'b00} +: NIB_W];
    assign sel_en = (state_q == SHOW) & mask[sel_q];

endmodule
